// File: rtl/bram_like_mem_pipe.sv
// bram_like_mem_pipe: true dual-port RAM with per-lane write masks, selectable
// same-port read-during-write behaviour, optional output register stage,
// write-write collision flag and a post-reset zeroing sweep.
module bram_like_mem_pipe #(
    parameter int DATA       = 36,
    parameter int ADDR       = 10,
    parameter int BYTE       = 9,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_ready,

    input  logic                   io_enable_1,
    input  logic                   io_write_1,
    input  logic [DATA/BYTE-1:0]   io_wmask_1,
    input  logic [ADDR-1:0]        io_addr_1,
    input  logic [DATA-1:0]        io_dataIn_1,
    output logic [DATA-1:0]        io_dataOut_1,
    output logic                   io_valid_1,

    input  logic                   io_enable_2,
    input  logic                   io_write_2,
    input  logic [DATA/BYTE-1:0]   io_wmask_2,
    input  logic [ADDR-1:0]        io_addr_2,
    input  logic [DATA-1:0]        io_dataIn_2,
    output logic [DATA-1:0]        io_dataOut_2,
    output logic                   io_valid_2,

    output logic                   io_collision
);
    localparam int NB    = DATA / BYTE;
    localparam int DEPTH = 1 << ADDR;

    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;

    state_t          state, state_next;
    logic [ADDR-1:0] cnt, cnt_next;
    logic            run_state;
    logic            clear_we;

    logic [DATA-1:0] mem [DEPTH];

    logic            acc_1, acc_2;
    logic            wr_1, wr_2;
    logic            fire_1, fire_2;
    logic            same_wr;
    logic [DATA-1:0] old_1, old_2;
    logic [DATA-1:0] merged_1, merged_2, both_merged;
    logic [DATA-1:0] word_1, word_2;

    logic            s1_valid_1, s1_valid_2;
    logic [DATA-1:0] s1_data_1, s1_data_2;
    logic            coll_q;

    // Control state and sweep counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: CLEAR zeroes one address per cycle, RUN accepts accesses
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        run_state  = 1'b0;
        clear_we   = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                cnt_next = cnt + ADDR'(1);
                if (cnt == '1) state_next = RUN;
            end
            RUN: run_state = 1'b1;
        endcase
    end

    assign io_ready = run_state & ~reset;

    // Lane merges: own-port write result, and the combined word for a
    // same-address write pair where port 1 overrides port 2 lane by lane
    for (genvar l = 0; l < NB; l++) begin : g_lane
        assign merged_1[l*BYTE +: BYTE] = io_wmask_1[l] ? io_dataIn_1[l*BYTE +: BYTE]
                                                         : old_1[l*BYTE +: BYTE];
        assign merged_2[l*BYTE +: BYTE] = io_wmask_2[l] ? io_dataIn_2[l*BYTE +: BYTE]
                                                         : old_2[l*BYTE +: BYTE];
        assign both_merged[l*BYTE +: BYTE] = io_wmask_1[l] ? io_dataIn_1[l*BYTE +: BYTE]
                                                            : merged_2[l*BYTE +: BYTE];
    end

    // Access decode and per-port output word selection
    always_comb begin
        acc_1   = io_enable_1 & io_ready;
        acc_2   = io_enable_2 & io_ready;
        wr_1    = acc_1 & io_write_1 & (|io_wmask_1);
        wr_2    = acc_2 & io_write_2 & (|io_wmask_2);
        same_wr = wr_1 & wr_2 & (io_addr_1 == io_addr_2);
        old_1   = mem[io_addr_1];
        old_2   = mem[io_addr_2];
        fire_1  = acc_1 & ~(wr_1 & (RDW_MODE == 2));
        fire_2  = acc_2 & ~(wr_2 & (RDW_MODE == 2));
        word_1  = (wr_1 && RDW_MODE == 0) ? merged_1 : old_1;
        word_2  = (wr_2 && RDW_MODE == 0) ? merged_2 : old_2;
    end

    // Memory array: clear sweep or port writes; never touched while in reset.
    // Same-address pairs are folded into one full-word write from port 1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clear_we) begin
                mem[cnt] <= '0;
            end else begin
                if (wr_2 && !same_wr) mem[io_addr_2] <= merged_2;
                if (wr_1)             mem[io_addr_1] <= same_wr ? both_merged : merged_1;
            end
        end
    end

    // First read stage and collision flag
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_1 <= 1'b0;
            s1_valid_2 <= 1'b0;
            s1_data_1  <= '0;
            s1_data_2  <= '0;
            coll_q     <= 1'b0;
        end else begin
            s1_valid_1 <= fire_1;
            s1_valid_2 <= fire_2;
            if (fire_1) s1_data_1 <= word_1;
            if (fire_2) s1_data_2 <= word_2;
            coll_q <= same_wr & (|(io_wmask_1 & io_wmask_2));
        end
    end

    assign io_collision = coll_q;

    if (OUT_REG != 0) begin : g_out_reg
        // Optional output stage: data only moves on a valid so it holds between pulses
        always_ff @(posedge clock) begin
            if (reset) begin
                io_valid_1   <= 1'b0;
                io_valid_2   <= 1'b0;
                io_dataOut_1 <= '0;
                io_dataOut_2 <= '0;
            end else begin
                io_valid_1 <= s1_valid_1;
                io_valid_2 <= s1_valid_2;
                if (s1_valid_1) io_dataOut_1 <= s1_data_1;
                if (s1_valid_2) io_dataOut_2 <= s1_data_2;
            end
        end
    end else begin : g_out_direct
        assign io_valid_1   = s1_valid_1;
        assign io_valid_2   = s1_valid_2;
        assign io_dataOut_1 = s1_data_1;
        assign io_dataOut_2 = s1_data_2;
    end

endmodule
